// File: rtl/exec_pkg.sv
// Shared execute-stage types and constants for the iterative multiply/divide units.
// No logic of its own; imported by the sequential datapaths and their helpers.
package exec_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int CNT_W     = $clog2(DEF_WIDTH);

endpackage

// File: rtl/abs_conv.sv
// Conditional two's-complement negate: dout = en ? -din : din (mod 2^W).
// Purely combinational, zero latency; no handshake, no backpressure.
module abs_conv #(
    parameter int W = 32
) (
    input  logic [W-1:0] din,
    input  logic         en,
    output logic [W-1:0] dout
);

    assign dout = en ? (~din + W'(1)) : din;

endmodule

// File: rtl/mul_seq.sv
// Radix-2 shift-add multiplier, signed/unsigned, 2*WIDTH-bit product in hi:lo; result WIDTH+1 cycles after start.
// No backpressure: start is always accepted and aborts any operation in flight; over holds until next start.
module mul_seq
    import exec_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             over,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    state_t             state;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      count;
    logic               neg;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     sum;

    // Magnitudes are unsigned WIDTH-bit values, so the most-negative operand maps to 2^(WIDTH-1).
    abs_conv #(.W(WIDTH)) u_abs_a (
        .din  (multiplicand),
        .en   (is_signed & multiplicand[WIDTH-1]),
        .dout (a_mag)
    );

    abs_conv #(.W(WIDTH)) u_abs_b (
        .din  (multiplier),
        .en   (is_signed & multiplier[WIDTH-1]),
        .dout (b_mag)
    );

    abs_conv #(.W(2*WIDTH)) u_fix (
        .din  (acc),
        .en   (neg),
        .dout (prod)
    );

    // Upper WIDTH+1 bits of the partial sum; the carry lands in the accumulator MSB after the shift.
    assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
            neg    <= 1'b0;
            busy   <= 1'b0;
            over   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else if (start) begin
            mcand  <= a_mag;
            mplier <= b_mag;
            neg    <= is_signed & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
            acc    <= '0;
            count  <= '0;
            busy   <= 1'b1;
            over   <= 1'b0;
            state  <= RUN;
        end else begin
            case (state)
                RUN: begin
                    acc    <= {sum, acc[WIDTH-1:1]};
                    mplier <= {acc[0], mplier[WIDTH-1:1]};
                    count  <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    {hi, lo} <= prod;
                    busy     <= 1'b0;
                    over     <= 1'b1;
                    state    <= IDLE;
                end
                IDLE: begin
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mul_seq.md
Name: mul_seq

Overview:
- Iterative radix-2 shift-add multiplier, the inverse of the sequential divider in the execute stage; it serves the MUL/IMUL-class instructions.
- It computes a 2*WIDTH-bit product (hi:lo) of two WIDTH-bit operands, signed or unsigned, over WIDTH+1 cycles.
- It uses the same start/busy/over handshake as the divider, so the execute-stage sequencer drives both blocks identically.

Parameters:
- WIDTH, 32, operand width in bits. Legal values are 8..64. The product is 2*WIDTH bits.

Ports:
- clock  in  1  Single clock; all state changes on its rising edge.
- resetn  in  1  Asynchronous, active-low reset.
- start  in  1  Sampled at the rising edge. When 1, latches the operands and begins a multiply.
- is_signed  in  1  Sampled with start. 1 = two's-complement operands, 0 = unsigned.
- multiplicand  in  WIDTH  Operand A, sampled with start only.
- multiplier  in  WIDTH  Operand B, sampled with start only.
- busy  out  1  High from the cycle after start until the result is written.
- over  out  1  Result-valid flag. Set when the result is written; held until the next start or reset.
- hi  out  WIDTH  Upper half of the product.
- lo  out  WIDTH  Lower half of the product.

Behaviour:
- Reset (resetn=0, asynchronous): state=IDLE, busy=0, over=0, hi=0, lo=0, count=0. All internal operand registers are cleared.
- States are IDLE, RUN and FIX.
- IDLE: when start=1 at edge E:
  - Latch |A| and |B|. Absolute values are taken only if is_signed=1 and the operand MSB=1; otherwise the raw bits are latched.
  - Latch neg = is_signed & (A[MSB] ^ B[MSB]).
  - Clear the accumulator (2*WIDTH bits) and count.
  - Set busy=1 and over=0, then go to RUN.
- Magnitude rule: |A| is formed as an unsigned WIDTH-bit value, so the most-negative input (e.g. 0x80000000) maps to 2^(WIDTH-1) without overflow.
- RUN: once per cycle:
  - If the multiplier-register LSB=1, add the multiplicand into the accumulator's upper WIDTH+1 bits.
  - Shift the accumulator:multiplier right by 1, with the carry entering the MSB.
  - Increment count.
  - After WIDTH iterations (count==WIDTH-1 at that edge), go to FIX.
- FIX, one cycle:
  - Product P = neg ? -acc : acc, computed mod 2^(2*WIDTH).
  - Set {hi,lo}=P, busy=0, over=1, and return to IDLE.
- Latency: with start sampled at edge E, busy=1 after E, RUN occupies edges E+1..E+WIDTH, and over=1 and busy=0 after edge E+WIDTH+1. For WIDTH=32 the result is valid 33 cycles after the start edge.
- Operand lifetime: operands are latched at start. Changes to multiplicand, multiplier or is_signed after start do not affect the result.
- Start while busy (RUN or FIX): the current operation is aborted and the new operands are latched. The sequence restarts from count=0, busy stays 1, and hi/lo keep their previous values.
- Start in the same edge that FIX would complete: start wins. No result is written, over stays 0, and the new operation begins.
- hi/lo change only in FIX and on reset. Between operations they hold the last result.
- Reset asserted mid-operation: immediate return to the reset state, with no result.
- Zero operand: the full WIDTH+1 cycles still elapse; there is no early termination. The result is 0, and neg is irrelevant because -0 = 0.

Decomposition:
- Shared package `exec_pkg` holds:
  - the state enum {IDLE, RUN, FIX};
  - the default WIDTH constant;
  - a localparam for the counter width, clog2(WIDTH).
- One natural sub-module, `abs_conv`: combinational conditional two's-complement negate (in, en -> out). It is instantiated for the two operand magnitudes and the 2*WIDTH-bit result fixup, and is reusable by the divider.
- The FSM, counter and accumulator stay in mul_seq.

Test Plan:
- Unsigned: is_signed=0, A=0xFFFFFFFF, B=0xFFFFFFFF -> after 33 cycles over=1, hi=0xFFFFFFFE, lo=0x00000001; busy=1 for exactly 33 cycles.
- Signed mixed sign: is_signed=1, A=0xFFFFFFF9 (-7), B=0x00000006 -> hi=0xFFFFFFFF, lo=0xFFFFFFD6 (-42).
- Most-negative square: is_signed=1, A=B=0x80000000 -> hi=0x40000000, lo=0x00000000. The same operands with is_signed=0 -> hi=0x40000000, lo=0.
- Abort/restart: start with A=3, B=5; at cycle 10 start again with A=0x10000, B=0x10000 -> single over pulse onset 33 cycles after the second start, hi=0x00000001, lo=0; hi/lo unchanged until then.
- Operand hold/reset: change A/B every cycle after start=1 (A=2, B=9) -> lo=18, hi=0. Then assert resetn=0 mid-RUN -> busy, over, hi and lo all 0 immediately, with no clock edge needed.
